ins_cache: RTL and testbench



---
 rtl/ins_cache.sv | 165 ++++++++++++++++
 tb/tb_ins_cache.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ins_cache.sv
// Instruction cache: holds one block of ISA_DEPTH instructions fetched from DDR and
// serves the instruction at addr_ins with one cycle of latency. A miss reloads the
// block that contains addr_ins.
// Optional build macro: INS_CACHE_STATS_EN adds saturating miss_cnt / hit_cnt outputs.
module ins_cache #(
    parameter int unsigned ADDR_WIDTH_MEM  = 16,
    parameter int unsigned ISA_DEPTH       = 64,
    parameter int unsigned TOTAL_ISA_DEPTH = 128,
    parameter int unsigned DDR_ADDR_WIDTH  = 28,
    parameter int unsigned ISA_WIDTH       = 64,
    parameter logic [DDR_ADDR_WIDTH-1:0] DDR_BASE_ISA = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    output logic                      ins_cache_rdy,
    output logic [3:0]                st_cur_ins_cache,
    output logic [9:0]                load_times,
    output logic [ISA_WIDTH-1:0]      ins_out,
    output logic                      ddr_rd_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
    input  logic                      ddr_rd_gnt,
    input  logic [ISA_WIDTH-1:0]      ddr_rd_data,
    input  logic                      ddr_rd_data_valid
`ifdef INS_CACHE_STATS_EN
    ,
    output logic [15:0]               miss_cnt,
    output logic [15:0]               hit_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(ISA_DEPTH);
    // One instruction occupies 8 DDR bytes, so a block spans ISA_DEPTH*8 bytes.
    localparam int unsigned BLK_SHIFT = IDX_W + 3;

    typedef enum logic [3:0] {
        StStart   = 4'd1,
        StLoadIns = 4'd2,
        StSentIns = 4'd3
    } state_e;

    state_e                      state_q;
    logic [IDX_W-1:0]            fill_q;
    logic [9:0]                  blk_q;
    logic                        gnt_seen_q;
    logic [ISA_WIDTH-1:0]        mem [ISA_DEPTH];

    logic                        addr_valid;
    logic [9:0]                  tgt_blk;
    logic                        miss;
    logic [DDR_ADDR_WIDTH-1:0]   tgt_addr;
    logic                        accept;
    logic                        fill_last;

    // Address decode: validity, target block, miss and block start byte address.
    always_comb begin
        addr_valid = 32'(addr_ins) < TOTAL_ISA_DEPTH;
        tgt_blk    = addr_valid ? 10'(addr_ins >> IDX_W) : 10'd0;
        // Invalid addresses (e.g. 16'h8000 during a jump) are never a miss.
        miss       = addr_valid &&
                     ((load_times == 10'd0) || (tgt_blk != load_times - 10'd1));
        tgt_addr   = DDR_BASE_ISA + (DDR_ADDR_WIDTH'(tgt_blk) << BLK_SHIFT);
        // Words count only once the request has been granted; a grant with data
        // in the same cycle already accepts that word.
        accept     = (state_q == StLoadIns) && ddr_rd_data_valid &&
                     (gnt_seen_q || (ddr_rd_req && ddr_rd_gnt));
        fill_last  = fill_q == IDX_W'(ISA_DEPTH - 1);
    end

    assign st_cur_ins_cache = state_q;

    // Block storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[fill_q] <= ddr_rd_data;
        end
    end

    // Cache control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StStart;
            load_times    <= 10'd0;
            ins_cache_rdy <= 1'b0;
            ins_out       <= '0;
            ddr_rd_req    <= 1'b0;
            ddr_rd_addr   <= '0;
            fill_q        <= '0;
            blk_q         <= 10'd0;
            gnt_seen_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StStart: begin
                    blk_q       <= tgt_blk;
                    ddr_rd_addr <= tgt_addr;
                    ddr_rd_req  <= 1'b1;
                    gnt_seen_q  <= 1'b0;
                    fill_q      <= '0;
                    state_q     <= StLoadIns;
                end
                StLoadIns: begin
                    if (ddr_rd_req && ddr_rd_gnt) begin
                        ddr_rd_req <= 1'b0;
                        gnt_seen_q <= 1'b1;
                    end
                    if (accept) begin
                        if (fill_last) begin
                            fill_q     <= '0;
                            load_times <= blk_q + 10'd1;
                            gnt_seen_q <= 1'b0;
                            state_q    <= StSentIns;
                        end else begin
                            fill_q <= fill_q + 1'b1;
                        end
                    end
                end
                StSentIns: begin
                    if (!addr_valid) begin
                        ins_cache_rdy <= 1'b0;
                    end else if (miss) begin
                        ins_cache_rdy <= 1'b0;
                        blk_q         <= tgt_blk;
                        ddr_rd_addr   <= tgt_addr;
                        ddr_rd_req    <= 1'b1;
                        gnt_seen_q    <= 1'b0;
                        fill_q        <= '0;
                        state_q       <= StLoadIns;
                    end else begin
                        ins_out       <= mem[addr_ins[IDX_W-1:0]];
                        ins_cache_rdy <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StStart;
                end
            endcase
        end
    end

`ifdef INS_CACHE_STATS_EN
    logic miss_evt;
    logic hit_evt;

    always_comb begin
        miss_evt = (state_q == StSentIns) && miss;
        hit_evt  = (state_q == StSentIns) && ins_cache_rdy;
    end

    // Saturating miss / hit statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_cnt <= 16'd0;
            hit_cnt  <= 16'd0;
        end else begin
            if (miss_evt && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
            if (hit_evt && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ins_cache.sv
// Self-checking bench for ins_cache: table-driven hit vectors plus directed
// sequences for block loads, misses, jumps and reset during a fill.
module tb_ins_cache;

    logic        clk;
    logic        rst;
    logic [15:0] addr_ins;
    logic        ins_cache_rdy;
    logic [3:0]  st_cur_ins_cache;
    logic [9:0]  load_times;
    logic [63:0] ins_out;
    logic        ddr_rd_req;
    logic [27:0] ddr_rd_addr;
    logic        ddr_rd_gnt;
    logic [63:0] ddr_rd_data;
    logic        ddr_rd_data_valid;
`ifdef INS_CACHE_STATS_EN
    logic [15:0] miss_cnt;
    logic [15:0] hit_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ins_cache dut (
        .clk               (clk),
        .rst               (rst),
        .addr_ins          (addr_ins),
        .ins_cache_rdy     (ins_cache_rdy),
        .st_cur_ins_cache  (st_cur_ins_cache),
        .load_times        (load_times),
        .ins_out           (ins_out),
        .ddr_rd_req        (ddr_rd_req),
        .ddr_rd_addr       (ddr_rd_addr),
        .ddr_rd_gnt        (ddr_rd_gnt),
        .ddr_rd_data       (ddr_rd_data),
        .ddr_rd_data_valid (ddr_rd_data_valid)
`ifdef INS_CACHE_STATS_EN
        ,
        .miss_cnt          (miss_cnt),
        .hit_cnt           (hit_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] addr;
        logic        rdy;
        logic [63:0] out;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] word_of(input int k);
        return {32'hC0DE_0000 + 32'(k), (32'(k) * 32'h0101_0101) ^ 32'hA5A5_A5A5};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 64'(st_cur_ins_cache), 64'd1);
        check({tag, "_load_times"}, 64'(load_times), 64'd0);
        check({tag, "_rdy"}, 64'(ins_cache_rdy), 64'd0);
        check({tag, "_ins_out"}, ins_out, 64'd0);
        check({tag, "_req"}, 64'(ddr_rd_req), 64'd0);
        check({tag, "_rd_addr"}, 64'(ddr_rd_addr), 64'd0);
    endtask

    // Answer a pending block request: optional pre-grant junk words, grant together
    // with word 0, one idle bubble mid-block, then the rest of the block.
    task automatic serve_block(input int blk, input int pre);
        int waited = 0;
        while (!ddr_rd_req && waited < 20) begin
            step();
            waited++;
        end
        check("req_seen", 64'(ddr_rd_req), 64'd1);
        if (!ddr_rd_req) return;
        check("rd_addr", 64'(ddr_rd_addr), 64'(blk * 512));
        for (int i = 0; i < pre; i++) begin
            ddr_rd_gnt        = 1'b0;
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = 64'hDEAD_BEEF_0000_0000 + 64'(i);
            step();
        end
        if (pre > 0) check("req_hold", 64'(ddr_rd_req), 64'd1);
        for (int i = 0; i < 64; i++) begin
            if (i == 31) begin
                ddr_rd_data_valid = 1'b0;
                ddr_rd_data       = '1;
                step();
            end
            ddr_rd_gnt        = (i == 0);
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = word_of(blk * 64 + i);
            step();
            if (i == 0) check("req_drop", 64'(ddr_rd_req), 64'd0);
            if (i == 62) check("still_loading", 64'(st_cur_ins_cache), 64'd2);
        end
        ddr_rd_gnt        = 1'b0;
        ddr_rd_data_valid = 1'b0;
        check("load_done_state", 64'(st_cur_ins_cache), 64'd3);
        check("load_done_lt", 64'(load_times), 64'(blk + 1));
        check("load_done_rdy", 64'(ins_cache_rdy), 64'd0);
    endtask

    initial begin
        rst               = 1'b0;
        addr_ins          = 16'd0;
        ddr_rd_gnt        = 1'b0;
        ddr_rd_data       = '0;
        ddr_rd_data_valid = 1'b0;

        for (int k = 0; k < 64; k++) begin
            vecs.push_back('{addr: 16'(k), rdy: 1'b1, out: word_of(k)});
        end
        vecs.push_back('{addr: 16'h8000, rdy: 1'b0, out: word_of(63)});
        vecs.push_back('{addr: 16'd62,   rdy: 1'b1, out: word_of(62)});
        vecs.push_back('{addr: 16'd128,  rdy: 1'b0, out: word_of(62)});
        vecs.push_back('{addr: 16'hFFFF, rdy: 1'b0, out: word_of(62)});
        vecs.push_back('{addr: 16'd0,    rdy: 1'b1, out: word_of(0)});

        // Reset state.
        step();
        step();
        check_reset_vals("reset");

        // Cold start, with pre-grant junk and grant coinciding with word 0.
        rst = 1'b1;
        serve_block(0, 3);
        step();
        check("cold_rdy", 64'(ins_cache_rdy), 64'd1);
        check("cold_out", ins_out, word_of(0));

        // Hits, invalid addresses and output hold, one-cycle latency.
        foreach (vecs[i]) begin
            addr_ins = vecs[i].addr;
            step();
            check($sformatf("vec%0d_rdy", i), 64'(ins_cache_rdy), 64'(vecs[i].rdy));
            check($sformatf("vec%0d_out", i), ins_out, vecs[i].out);
            check($sformatf("vec%0d_req", i), 64'(ddr_rd_req), 64'd0);
            check($sformatf("vec%0d_state", i), 64'(st_cur_ins_cache), 64'd3);
        end

        // Block boundary: addr 64 with block 0 held.
        addr_ins = 16'd64;
        step();
        check("bnd_rdy", 64'(ins_cache_rdy), 64'd0);
        check("bnd_req", 64'(ddr_rd_req), 64'd1);
        check("bnd_state", 64'(st_cur_ins_cache), 64'd2);
        serve_block(1, 0);
        step();
        check("bnd_lt", 64'(load_times), 64'd2);
        check("bnd_out_rdy", 64'(ins_cache_rdy), 64'd1);
        check("bnd_out", ins_out, word_of(64));
`ifdef INS_CACHE_STATS_EN
        check("stats_miss", 64'(miss_cnt), 64'd1);
`endif

        // Jump address 16'h8000, then return into block 0.
        addr_ins = 16'h8000;
        for (int i = 0; i < 5; i++) begin
            step();
            check("jmp_rdy", 64'(ins_cache_rdy), 64'd0);
            check("jmp_req", 64'(ddr_rd_req), 64'd0);
            check("jmp_state", 64'(st_cur_ins_cache), 64'd3);
        end
        addr_ins = 16'd3;
        step();
        check("back_req", 64'(ddr_rd_req), 64'd1);
        check("back_addr", 64'(ddr_rd_addr), 64'd0);
        check("back_state", 64'(st_cur_ins_cache), 64'd2);
        serve_block(0, 0);
        step();
        check("back_lt", 64'(load_times), 64'd1);
        check("back_rdy", 64'(ins_cache_rdy), 64'd1);
        check("back_out", ins_out, word_of(3));

        // Reset after 20 words of a fill, stray data before the next grant.
        addr_ins = 16'd100;
        step();
        check("rm_req", 64'(ddr_rd_req), 64'd1);
        check("rm_addr", 64'(ddr_rd_addr), 64'd512);
        for (int i = 0; i < 20; i++) begin
            ddr_rd_gnt        = (i == 0);
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = word_of(64 + i);
            step();
        end
        ddr_rd_gnt = 1'b0;
        ddr_rd_data = 64'h0BAD_0BAD_0BAD_0BAD;
        rst = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        step();
        step();
        rst = 1'b1;
        serve_block(1, 2);
        step();
        check("rm_lt", 64'(load_times), 64'd2);
        check("rm_rdy", 64'(ins_cache_rdy), 64'd1);
        check("rm_out", ins_out, word_of(100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
